mem_initiator: RTL and testbench
================================

// Module: mem_initiator
// PURPOSE
//  Bus master for the 8x256-bit matrix memory (en/rw/address/datain/dataout, 1-cycle registered read).
//  On a start command it reads two 4x4x16 operand matrices, hands them to the matrix ALU over a valid/ready
//  handshake, waits for the ALU result, writes the result back to memory, then pulses done.
//  Sits between the top-level instruction sequencer and the memory/ALU pair.
// PARAMETERS
//  DATA_W  256  matrix word width (4x4x16 bit)
//  ADDR_W  3    memory address width (8 locations)
//  OP_W    4    opcode width forwarded to ALU
// PORTS
//  clk        in   1       single clock, all state changes on posedge
//  reset      in   1       asynchronous, active-high; forces IDLE
//  start      in   1       command strobe, sampled only in IDLE
//  op_code    in   OP_W    ALU opcode, latched with start
//  src_a      in   ADDR_W  address of operand A, latched with start
//  src_b      in   ADDR_W  address of operand B, latched with start
//  dst        in   ADDR_W  result address, latched with start
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse after result write
//  mem_en     out  1       memory enable
//  mem_rw     out  1       1=read, 0=write
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data (Z when memory disabled)
//  op_valid   out  1       operands + opcode valid to ALU
//  op_ready   in   1       ALU accepts operands
//  alu_op     out  OP_W    latched opcode
//  op_a       out  DATA_W  captured operand A
//  op_b       out  DATA_W  captured operand B
//  res_valid  in   1       ALU result valid (held until res_ready)
//  res_ready  out  1       initiator accepts result
//  res_data   in   DATA_W  ALU result
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mem_en, mem_rw, op_valid, res_ready = 0; mem_addr=0; mem_wdata, op_a,
//   op_b = 0; alu_op=0; latched addresses cleared. Reset mid-operation abandons the command, no write issued.
//  Memory timing: read issued in cycle N (en=1,rw=1,addr); mem_rdata valid in N+1, captured at end of N+1.
//   Write: en=1,rw=0,addr,wdata driven one cycle; memory stores at that edge. mem_rdata ignored at all other times.
//  FSM (one state per cycle unless noted):
//   IDLE   : en=0. start=1 -> latch op_code/src_a/src_b/dst, -> RD_A. start=0 -> stay.
//   RD_A   : en=1,rw=1,addr=src_a -> RD_B.
//   RD_B   : en=1,rw=1,addr=src_b; capture mem_rdata into op_a -> CAP_B.
//   CAP_B  : en=0; capture mem_rdata into op_b -> OFFER.
//   OFFER  : op_valid=1, op_a/op_b/alu_op stable; stay until op_ready=1 (transfer on edge with both high) -> WAIT_R.
//   WAIT_R : res_ready=1; stay until res_valid=1; on that edge latch res_data into mem_wdata -> WR.
//   WR     : en=1,rw=0,addr=dst,wdata=latched result -> DONE.
//   DONE   : done=1 for exactly one cycle, en=0 -> IDLE (busy low next cycle).
//  Minimum latency: start sampled at edge E0; done high in cycle 7 after E0 when op_ready and res_valid are
//   already high on entry. Next start accepted the cycle after DONE (no back-to-back overlap).
//  Boundaries:
//   start while busy: ignored, no queueing; inputs changing while busy have no effect.
//   src_a==src_b: two reads of same location, op_a==op_b.
//   dst equal to src_a/src_b: allowed; reads complete before write, new value visible to next command.
//   res_valid high during OFFER: ignored until WAIT_R (res_ready low outside WAIT_R).
//   op_ready without op_valid: no effect. op_valid deasserts the cycle after handshake.
//   op_a/op_b/alu_op hold their values until next command's capture.
//   Widths: all data paths DATA_W exact, no arithmetic performed in this block.
// STRUCTURE
//  Shared include mat_defs.vh: DATA_W/ADDR_W/OP_W defaults, FSM state localparams (3-bit encoding
//   IDLE=0..DONE=7), MEM_RD=1 / MEM_WR=0 constants. Single flat module; no sub-module is natural.
// TESTING (bench instantiates memory + ALU stub; mem[0]=0x0004000C...00100003, mem[1]=0x0017002D...00070013)
//  1 start src_a=0,src_b=1,dst=2, ALU stub ready/valid immediate, result=A^B -> op_a=mem[0], op_b=mem[1];
//    mem[2]=mem[0]^mem[1]; done in cycle 7; en/rw/addr sequence per FSM exactly.
//  2 op_ready delayed 3 cycles, res_valid delayed 5 -> op_valid held steady 4 cycles, res_ready held;
//    done at cycle 7+8=15; no memory access during waits (en=0).
//  3 src_a=src_b=1, dst=1, result=0xFFFF..FF -> op_a==op_b==mem[1]; mem[1] becomes all ones;
//    second command reading 1 returns all ones.
//  4 start pulsed in RD_B and WAIT_R with different addresses -> ignored; only first command's write occurs.
//  5 reset asserted asynchronously in WAIT_R -> outputs zero immediately, no write to dst, mem[dst] unchanged;
//    fresh start after release completes normally.
//  6 res_valid asserted during OFFER -> not consumed until WAIT_R; res_ready=0 in OFFER; written value correct.

Source files
------------

// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg: widths, FSM encoding and next-state rule shared by the matrix memory initiator.
package mem_initiator_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_A   = 3'd1;
    localparam logic [2:0] S_RD_B   = 3'd2;
    localparam logic [2:0] S_CAP_B  = 3'd3;
    localparam logic [2:0] S_OFFER  = 3'd4;
    localparam logic [2:0] S_WAIT_R = 3'd5;
    localparam logic [2:0] S_WR     = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] d;
    } cmd_t;

    // Only IDLE, OFFER and WAIT_R can stall; every other state advances in encoding order.
    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic start,
                                            input logic op_ready, input logic res_valid);
        return s == S_IDLE   ? (start     ? S_RD_A   : S_IDLE)   :
               s == S_OFFER  ? (op_ready  ? S_WAIT_R : S_OFFER)  :
               s == S_WAIT_R ? (res_valid ? S_WR     : S_WAIT_R) :
               s == S_DONE   ? S_IDLE : s + 3'd1;
    endfunction

endpackage

// File: rtl/mem_initiator.sv
// mem_initiator: reads two matrix operands, hands them to the ALU, writes the result back, pulses done.
module mem_initiator
    import mem_initiator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op_code,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data
);

    logic [2:0] state;
    logic [2:0] state_nx;
    cmd_t       cmd;
    logic       rd;

    always_comb state_nx = fsm_next(state, start, op_ready, res_valid);

    // Read data lags the address by one cycle, so A lands during RD_B and B during CAP_B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd       <= '0;
            alu_op    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                cmd    <= '{a: src_a, b: src_b, d: dst};
                alu_op <= op_code;
            end
            if (state == S_RD_B)
                op_a <= mem_rdata;
            if (state == S_CAP_B)
                op_b <= mem_rdata;
            if (state == S_WAIT_R && res_valid)
                mem_wdata <= res_data;
        end
    end

    assign rd        = state == S_RD_A || state == S_RD_B;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign mem_en    = rd || state == S_WR;
    assign mem_rw    = rd ? MEM_RD : MEM_WR;
    assign mem_addr  = state == S_RD_A ? cmd.a :
                       state == S_RD_B ? cmd.b :
                       state == S_WR   ? cmd.d : '0;
    assign op_valid  = state == S_OFFER;
    assign res_ready = state == S_WAIT_R;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized scoreboard bench with a memory model, an ALU stub and a reference model.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic [OP_W-1:0]   op_code;
    logic [ADDR_W-1:0] src_a, src_b, dst;
    logic              busy, done, mem_en, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              op_valid, op_ready;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] op_a, op_b;
    logic              res_valid, res_ready;
    logic [DATA_W-1:0] res_data;

    mem_initiator dut (
        .clk(clk), .reset(reset), .start(start), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .dst(dst), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .op_valid(op_valid), .op_ready(op_ready), .alu_op(alu_op),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [DATA_W-1:0] M0 =
        256'h0004000C_00010002_00030004_00050006_00070008_0009000A_000B000C_00100003;
    localparam logic [DATA_W-1:0] M1 =
        256'h0017002D_00110012_00130014_00150016_00170018_0019001A_001B001C_00070013;

    // Memory model: registered read, garbage on the bus when no read data is due.
    logic [DATA_W-1:0] mem [8];
    logic [DATA_W-1:0] ld_img [8];
    logic [DATA_W-1:0] rq;
    logic              rv = 1'b0;
    logic              ld = 1'b0;

    always @(posedge clk) begin
        rv <= mem_en && mem_rw;
        if (mem_en && mem_rw)
            rq <= mem[mem_addr];
        if (mem_en && !mem_rw)
            mem[mem_addr] <= mem_wdata;
        if (ld)
            for (int i = 0; i < 8; i++)
                mem[i] <= ld_img[i];
    end
    assign mem_rdata = rv ? rq : {8{32'hDEADBEEF}};

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return op[1:0] == 2'd0 ? a ^ b :
               op[1:0] == 2'd1 ? {DATA_W{1'b1}} :
               op[1:0] == 2'd2 ? a & b : a | b;
    endfunction

    // ALU stub with programmable handshake delays.
    int                rdy_dly = 0, val_dly = 0, ocnt, rcnt;
    bit                early = 1'b0;
    logic              noise = 1'b0;
    logic              pend;
    logic [DATA_W-1:0] alu_q;

    always @(negedge clk) noise <= 1'($urandom);

    assign op_ready  = op_valid ? (ocnt >= rdy_dly) : noise;
    assign res_valid = pend ? (rcnt >= val_dly) : (early && op_valid);
    assign res_data  = pend ? alu_q : alu_f(alu_op, op_a, op_b);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            ocnt <= 0;
            rcnt <= 0;
        end else begin
            ocnt <= (op_valid && !op_ready) ? ocnt + 1 : 0;
            if (op_valid && op_ready) begin
                pend  <= 1'b1;
                rcnt  <= 0;
                alu_q <= alu_f(alu_op, op_a, op_b);
            end else if (pend && res_valid && res_ready)
                pend <= 1'b0;
            else if (pend && !res_valid)
                rcnt <= rcnt + 1;
        end
    end

    typedef struct {
        int                c;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;
    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } ops_t;

    acc_t acc_q[$];
    ops_t ops_q[$];
    int   done_q[$];
    logic [DATA_W-1:0] mm [8];
    int checks = 0;
    int fails = 0;

    function automatic void check_w(input string nm, input logic [DATA_W-1:0] act,
                                    input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void check_n(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    // Monitor: every memory access, operand transfer and done pulse is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en) begin
                if (acc_q.size() == 0)
                    check_n("unexpected_access", int'(mem_addr), -1);
                else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check_n("acc_cycle", cyc, e.c);
                    check_n("acc_rw", int'(mem_rw), int'(e.rw));
                    check_n("acc_addr", int'(mem_addr), int'(e.addr));
                    if (!e.rw)
                        check_w("wr_data", mem_wdata, e.data);
                end
            end
            if (op_valid && op_ready) begin
                if (ops_q.size() == 0)
                    check_n("unexpected_handshake", 1, 0);
                else begin
                    ops_t o;
                    o = ops_q.pop_front();
                    check_w("op_a", op_a, o.a);
                    check_w("op_b", op_b, o.b);
                    check_n("alu_op", int'(alu_op), int'(o.op));
                end
            end
            if (done)
                check_n("done_cycle", cyc, done_q.size() ? done_q.pop_front() : -1);
            if (op_valid && res_ready)
                check_n("res_ready_in_offer", 1, 0);
        end
    end

    task automatic rst_checks(input string tag);
        check_n({tag, "_busy"}, int'(busy), 0);
        check_n({tag, "_done"}, int'(done), 0);
        check_n({tag, "_mem_en"}, int'(mem_en), 0);
        check_n({tag, "_mem_rw"}, int'(mem_rw), 0);
        check_n({tag, "_mem_addr"}, int'(mem_addr), 0);
        check_n({tag, "_op_valid"}, int'(op_valid), 0);
        check_n({tag, "_res_ready"}, int'(res_ready), 0);
        check_n({tag, "_alu_op"}, int'(alu_op), 0);
        check_w({tag, "_mem_wdata"}, mem_wdata, '0);
        check_w({tag, "_op_a"}, op_a, '0);
        check_w({tag, "_op_b"}, op_b, '0);
    endtask

    // Issue one command; while it runs, hammer start/address inputs with junk that must be ignored.
    task automatic issue(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d,
                         input int rd, input int vd, input bit e, input bit abort);
        int k;
        logic [DATA_W-1:0] va, vb, r;
        for (int i = 0; i < 20 && busy; i++)
            @(negedge clk);
        rdy_dly = rd;
        val_dly = vd;
        early   = e;
        op_code = op;
        src_a   = a;
        src_b   = b;
        dst     = d;
        start   = 1'b1;
        k       = cyc;
        va = mm[a];
        vb = mm[b];
        ops_q.push_back('{va, vb, op});
        acc_q.push_back('{k + 1, MEM_RD, a, '0});
        acc_q.push_back('{k + 2, MEM_RD, b, '0});
        if (!abort) begin
            r = alu_f(op, va, vb);
            mm[d] = r;
            acc_q.push_back('{k + 6 + rd + vd, MEM_WR, d, r});
            done_q.push_back(k + 7 + rd + vd);
        end
        @(negedge clk);
        check_n("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 300; i++) begin
            start   = 1'($urandom);
            op_code = 4'($urandom);
            src_a   = 3'($urandom);
            src_b   = 3'($urandom);
            dst     = 3'($urandom);
            if (abort && res_ready) begin
                start = 1'b0;
                #2 reset = 1'b1;
                #1 rst_checks("abort");
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                check_n("done_low_idle", int'(done), 0);
                break;
            end
            if (i == 299)
                check_n("cmd_timeout", 1, 0);
        end
    endtask

    initial begin
        start = 1'b0;
        op_code = '0;
        src_a = '0;
        src_b = '0;
        dst = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        ld_img[0] = M0;
        ld_img[1] = M1;
        for (int i = 2; i < 8; i++)
            ld_img[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++)
            mm[i] = ld_img[i];
        ld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ld = 1'b0;
        rst_checks("reset");
        reset = 1'b0;
        @(negedge clk);

        issue(4'd0, 3'd0, 3'd1, 3'd2, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_w("mem2_xor", mem[2], M0 ^ M1);
        issue(4'd0, 3'd0, 3'd1, 3'd3, 3, 5, 1'b0, 1'b0);
        issue(4'd1, 3'd1, 3'd1, 3'd1, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_w("mem1_ones", mem[1], {DATA_W{1'b1}});
        issue(4'd3, 3'd1, 3'd0, 3'd4, 1, 0, 1'b0, 1'b0);
        issue(4'd2, 3'd3, 3'd4, 3'd5, 1, 50, 1'b0, 1'b1);
        @(negedge clk);
        check_w("mem5_untouched", mem[5], mm[5]);
        issue(4'd0, 3'd3, 3'd4, 3'd5, 0, 1, 1'b0, 1'b0);
        issue(4'd3, 3'd0, 3'd1, 3'd6, 4, 0, 1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            bit ab;
            ab = ($urandom_range(0, 7) == 0);
            issue(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), ab ? 50 : int'($urandom_range(0, 3)),
                  1'($urandom), ab);
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++)
            check_w($sformatf("final_mem%0d", i), mem[i], mm[i]);
        check_n("acc_q_empty", acc_q.size(), 0);
        check_n("ops_q_empty", ops_q.size(), 0);
        check_n("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
